sd_spi_master: RTL and testbench

Parametrised SPI master for SD cards and other SPI peripherals on the machine's I/O bus. It runs several chip selects at a programmable SCLK rate. Commands are single pulses from the CPU-side port; the block also offers a hardware "wait for non-0xFF" response poll, so firmware does not have to spin on byte transfers. It sits between the CPU I/O decoder and the board SPI pins: MISO is SD_DATA[0], MOSI is SD_CMD, SCLK is SD_CLK, and CS[0] is SD_DATA[3].

---
 rtl/sd_spi_master.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_sd_spi_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master.sv
// sd_spi_master
//   SPI master for SD cards and other SPI peripherals. The CPU issues single
//   commands via a rising edge on sd_signal. Supported commands: card init
//   clocking, byte exchange, chip-select control, divider control, and a
//   hardware "wait for non-0xFF" response poll.
//
// Ports
//   clock50    system clock, rising edge
//   reset      synchronous active-high reset
//   SPI_CS     chip selects, active low (CS[0] is SD_DATA[3])
//   SPI_SCLK   serial clock, mode 0
//   SPI_MISO   serial data in (SD_DATA[0])
//   SPI_MOSI   serial data out, MSB first (SD_CMD)
//   sd_signal  command strobe, a 0->1 edge starts a command
//   sd_cmd     command id (0 INIT, 1 XFER, 2 CS_ON, 3 CS_OFF,
//              4 SPEED, 5 SLOW, 6 WAIT, 7 no-op)
//   sd_sel     chip-select index for CS_ON
//   sd_out     TX byte for XFER, divider for SPEED
//   sd_din     last received byte
//   sd_busy    high while a command executes
//   sd_timeout idle timeout reached
//   sd_err     last WAIT ran out of bytes without a response
module sd_spi_master #(
    parameter int SLOW_DIV    = 250,
    parameter int INIT_CLOCKS = 80,
    parameter int CS_COUNT    = 2,
    parameter int WAIT_MAX    = 256,
    parameter int TIMEOUT_CNT = 5000000,
    localparam int SELW = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
    input  logic                clock50,
    input  logic                reset,
    output logic [CS_COUNT-1:0] SPI_CS,
    output logic                SPI_SCLK,
    input  logic                SPI_MISO,
    output logic                SPI_MOSI,
    input  logic                sd_signal,
    input  logic [2:0]          sd_cmd,
    input  logic [SELW-1:0]     sd_sel,
    input  logic [7:0]          sd_out,
    output logic [7:0]          sd_din,
    output logic                sd_busy,
    output logic                sd_timeout,
    output logic                sd_err
);

    localparam int DIV_W  = ($clog2(SLOW_DIV + 1) > 8) ? $clog2(SLOW_DIV + 1) : 8;
    localparam int TOG_W  = $clog2(2 * INIT_CLOCKS + 1);
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CNT + 1);

    localparam logic [2:0] CMD_INIT   = 3'd0;
    localparam logic [2:0] CMD_XFER   = 3'd1;
    localparam logic [2:0] CMD_CS_ON  = 3'd2;
    localparam logic [2:0] CMD_CS_OFF = 3'd3;
    localparam logic [2:0] CMD_SPEED  = 3'd4;
    localparam logic [2:0] CMD_SLOW   = 3'd5;
    localparam logic [2:0] CMD_WAIT   = 3'd6;

    typedef enum logic [2:0] {
        IDLE, INIT, XFER_LO, XFER_HI, WAIT_CHK, CSDLY
    } state_t;

    state_t state, state_nxt;

    logic [1:0]          sig_sr;
    logic                start;

    logic [2:0]          cmd, cmd_nxt;
    logic [SELW-1:0]     sel, sel_nxt;
    logic [7:0]          tx, tx_nxt;
    logic [7:0]          rx, rx_nxt;
    logic [DIV_W-1:0]    cnt, cnt_nxt;
    logic [DIV_W-1:0]    div, div_nxt;
    logic [2:0]          bitn, bitn_nxt;
    logic [TOG_W-1:0]    tog, tog_nxt;
    logic [WCNT_W-1:0]   nbytes, nbytes_nxt, nbytes_inc;
    logic [TMO_W-1:0]    tmo, tmo_nxt;

    logic [CS_COUNT-1:0] cs_q, cs_nxt, cs_sel_val;
    logic                sclk_q, sclk_nxt;
    logic                mosi_q, mosi_nxt;
    logic [7:0]          din_q, din_nxt;
    logic                err_q, err_nxt;

    assign start      = (sig_sr == 2'b01) && (state == IDLE);
    assign nbytes_inc = nbytes + WCNT_W'(1);

    // One-hot-low select pattern; an out-of-range index matches no line.
    always_comb begin
        cs_sel_val = '1;
        for (int i = 0; i < CS_COUNT; i++) begin
            if (sel == SELW'(i)) cs_sel_val[i] = 1'b0;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cmd_nxt    = cmd;
        sel_nxt    = sel;
        tx_nxt     = tx;
        rx_nxt     = rx;
        cnt_nxt    = cnt;
        div_nxt    = div;
        bitn_nxt   = bitn;
        tog_nxt    = tog;
        nbytes_nxt = nbytes;
        cs_nxt     = cs_q;
        sclk_nxt   = sclk_q;
        mosi_nxt   = mosi_q;
        din_nxt    = din_q;
        err_nxt    = err_q;

        case (state)
            IDLE: begin
                if (start) begin
                    cmd_nxt  = sd_cmd;
                    sel_nxt  = sd_sel;
                    // Two wait cycles plus the write cycle for the CS delay path.
                    cnt_nxt  = DIV_W'(2);
                    case (sd_cmd)
                        CMD_INIT: begin
                            cs_nxt    = '1;
                            mosi_nxt  = 1'b1;
                            sclk_nxt  = 1'b0;
                            div_nxt   = DIV_W'(SLOW_DIV);
                            cnt_nxt   = DIV_W'(SLOW_DIV - 1);
                            tog_nxt   = '0;
                            state_nxt = INIT;
                        end
                        CMD_XFER: begin
                            tx_nxt    = sd_out;
                            mosi_nxt  = sd_out[7];
                            sclk_nxt  = 1'b0;
                            cnt_nxt   = div - DIV_W'(1);
                            bitn_nxt  = '0;
                            state_nxt = XFER_LO;
                        end
                        CMD_WAIT: begin
                            tx_nxt     = 8'hFF;
                            mosi_nxt   = 1'b1;
                            sclk_nxt   = 1'b0;
                            cnt_nxt    = div - DIV_W'(1);
                            bitn_nxt   = '0;
                            nbytes_nxt = '0;
                            err_nxt    = 1'b0;
                            state_nxt  = XFER_LO;
                        end
                        CMD_SPEED: begin
                            div_nxt   = (sd_out == 8'd0) ? DIV_W'(1) : DIV_W'(sd_out);
                            state_nxt = CSDLY;
                        end
                        CMD_SLOW: begin
                            div_nxt   = DIV_W'(SLOW_DIV);
                            state_nxt = CSDLY;
                        end
                        default: state_nxt = CSDLY;
                    endcase
                end
            end

            // After the last toggle SCLK is already low; one more cycle
            // releases MOSI and finishes.
            INIT: begin
                if (tog == TOG_W'(2 * INIT_CLOCKS)) begin
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    sclk_nxt = ~sclk_q;
                    tog_nxt  = tog + TOG_W'(1);
                    cnt_nxt  = DIV_W'(SLOW_DIV - 1);
                end else begin
                    cnt_nxt = cnt - DIV_W'(1);
                end
            end

            XFER_LO: begin
                if (cnt == '0) begin
                    sclk_nxt  = 1'b1;
                    rx_nxt    = {rx[6:0], SPI_MISO};
                    cnt_nxt   = div - DIV_W'(1);
                    state_nxt = XFER_HI;
                end else begin
                    cnt_nxt = cnt - DIV_W'(1);
                end
            end

            // TX shifts in ones so a WAIT keeps MOSI high on every bit.
            XFER_HI: begin
                if (cnt == '0) begin
                    sclk_nxt = 1'b0;
                    if (bitn == 3'd7) begin
                        mosi_nxt  = 1'b0;
                        state_nxt = WAIT_CHK;
                    end else begin
                        tx_nxt    = {tx[6:0], 1'b1};
                        mosi_nxt  = tx[6];
                        bitn_nxt  = bitn + 3'd1;
                        cnt_nxt   = div - DIV_W'(1);
                        state_nxt = XFER_LO;
                    end
                end else begin
                    cnt_nxt = cnt - DIV_W'(1);
                end
            end

            // Byte complete: publish it and, for WAIT, decide whether to poll again.
            WAIT_CHK: begin
                din_nxt   = rx;
                state_nxt = IDLE;
                if (cmd == CMD_WAIT && rx == 8'hFF) begin
                    if (nbytes_inc == WCNT_W'(WAIT_MAX)) begin
                        err_nxt = 1'b1;
                    end else begin
                        nbytes_nxt = nbytes_inc;
                        tx_nxt     = 8'hFF;
                        mosi_nxt   = 1'b1;
                        bitn_nxt   = '0;
                        cnt_nxt    = div - DIV_W'(1);
                        state_nxt  = XFER_LO;
                    end
                end
            end

            CSDLY: begin
                if (cnt == '0) begin
                    if (cmd == CMD_CS_ON)  cs_nxt = cs_sel_val;
                    if (cmd == CMD_CS_OFF) cs_nxt = '1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - DIV_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Idle timer: cleared by each command, counts only while idle, sticks at the limit.
    always_comb begin
        tmo_nxt = tmo;
        if (start)
            tmo_nxt = '0;
        else if (state == IDLE && tmo != TMO_W'(TIMEOUT_CNT))
            tmo_nxt = tmo + TMO_W'(1);
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            sig_sr <= 2'b00;
            cs_q   <= '1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            din_q  <= 8'h00;
            err_q  <= 1'b0;
            div    <= DIV_W'(SLOW_DIV);
            tmo    <= TMO_W'(TIMEOUT_CNT);
        end else begin
            sig_sr <= {sig_sr[0], sd_signal};
            cs_q   <= cs_nxt;
            sclk_q <= sclk_nxt;
            mosi_q <= mosi_nxt;
            din_q  <= din_nxt;
            err_q  <= err_nxt;
            div    <= div_nxt;
            tmo    <= tmo_nxt;
        end
    end

    // Working registers; only meaningful once a command has loaded them.
    always_ff @(posedge clock50) begin
        cmd    <= cmd_nxt;
        sel    <= sel_nxt;
        tx     <= tx_nxt;
        rx     <= rx_nxt;
        cnt    <= cnt_nxt;
        bitn   <= bitn_nxt;
        tog    <= tog_nxt;
        nbytes <= nbytes_nxt;
    end

    assign SPI_CS     = cs_q;
    assign SPI_SCLK   = sclk_q;
    assign SPI_MOSI   = mosi_q;
    assign sd_din     = din_q;
    assign sd_err     = err_q;
    assign sd_busy    = (state != IDLE);
    assign sd_timeout = (tmo == TMO_W'(TIMEOUT_CNT));

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master
//   Scoreboarded bench for sd_spi_master. Each command pushes its expected
//   completion (sd_din, SPI_CS, sd_err, busy length) when issued; a monitor
//   pops and compares when sd_busy falls. An SPI device model replays MISO
//   bytes and records MOSI and SCLK timing.
module tb_sd_spi_master;

    localparam int SLOW_DIV    = 250;
    localparam int INIT_CLOCKS = 80;
    localparam int CS_COUNT    = 3;
    localparam int WAIT_MAX    = 256;
    localparam int TIMEOUT_CNT = 300;
    localparam int SELW        = 2;

    logic                clock50 = 1'b0;
    logic                reset   = 1'b1;
    logic [CS_COUNT-1:0] SPI_CS;
    logic                SPI_SCLK;
    logic                SPI_MISO;
    logic                SPI_MOSI;
    logic                sd_signal = 1'b0;
    logic [2:0]          sd_cmd    = 3'd0;
    logic [SELW-1:0]     sd_sel    = '0;
    logic [7:0]          sd_out    = 8'h00;
    logic [7:0]          sd_din;
    logic                sd_busy;
    logic                sd_timeout;
    logic                sd_err;

    sd_spi_master #(
        .SLOW_DIV(SLOW_DIV), .INIT_CLOCKS(INIT_CLOCKS), .CS_COUNT(CS_COUNT),
        .WAIT_MAX(WAIT_MAX), .TIMEOUT_CNT(TIMEOUT_CNT)
    ) dut (
        .clock50(clock50), .reset(reset), .SPI_CS(SPI_CS), .SPI_SCLK(SPI_SCLK),
        .SPI_MISO(SPI_MISO), .SPI_MOSI(SPI_MOSI), .sd_signal(sd_signal),
        .sd_cmd(sd_cmd), .sd_sel(sd_sel), .sd_out(sd_out), .sd_din(sd_din),
        .sd_busy(sd_busy), .sd_timeout(sd_timeout), .sd_err(sd_err)
    );

    always #5 clock50 = ~clock50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clock50) cyc++;

    // ---------------- device model ----------------
    logic [7:0] dev_q[$];
    logic [7:0] dev_fill = 8'hFF;
    logic [7:0] dev_sh   = 8'hFF;
    int         dev_bit  = 0;
    assign SPI_MISO = dev_sh[7];

    function automatic logic [7:0] dev_next();
        if (dev_q.size() > 0) return dev_q.pop_front();
        return dev_fill;
    endfunction

    task automatic dev_prime();
        dev_bit = 0;
        dev_sh  = dev_next();
    endtask

    int         rises     = 0;
    logic [7:0] mosi_sh   = 8'h00;
    int         last_rise = -1;
    int         hi_min, hi_max, per_min, per_max;

    task automatic stats_clear();
        last_rise = -1;
        hi_min = 1000000; hi_max = 0; per_min = 1000000; per_max = 0;
    endtask

    always @(posedge SPI_SCLK) begin
        mosi_sh = {mosi_sh[6:0], SPI_MOSI};
        if (last_rise >= 0) begin
            if (cyc - last_rise < per_min) per_min = cyc - last_rise;
            if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        rises++;
    end

    always @(negedge SPI_SCLK) begin
        if (last_rise >= 0) begin
            if (cyc - last_rise < hi_min) hi_min = cyc - last_rise;
            if (cyc - last_rise > hi_max) hi_max = cyc - last_rise;
        end
        if (dev_bit == 7) begin
            dev_bit = 0;
            dev_sh  = dev_next();
        end else begin
            dev_bit++;
            dev_sh = {dev_sh[6:0], 1'b1};
        end
    end

    logic init_mon  = 1'b0;
    int   init_viol = 0;
    always @(negedge clock50)
        if (init_mon && sd_busy && (SPI_CS != 3'b111 || SPI_MOSI !== 1'b1)) init_viol++;

    // ---------------- scoreboard ----------------
    typedef struct {
        string      tag;
        logic [7:0] din;
        logic [2:0] cs;
        logic       err;
        int         busy;
    } exp_t;
    exp_t sb[$];

    int   busy_cnt  = 0;
    logic busy_prev = 1'b0;
    int   cyc_done  = 0;

    always @(negedge clock50) begin
        if (reset) begin
            busy_cnt  = 0;
            busy_prev = 1'b0;
        end else begin
            if (sd_busy) begin
                busy_cnt++;
            end else if (busy_prev) begin
                cyc_done = cyc;
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, "_busy"}, busy_cnt, e.busy);
                    check({e.tag, "_din"},  sd_din,   e.din);
                    check({e.tag, "_cs"},   SPI_CS,   e.cs);
                    check({e.tag, "_err"},  sd_err,   e.err);
                end
                busy_cnt = 0;
            end
            busy_prev = sd_busy;
        end
    end

    // Model of architectural state the bench expects.
    logic [7:0] m_din = 8'h00;
    logic [2:0] m_cs  = 3'b111;
    logic       m_err = 1'b0;
    int         m_d   = SLOW_DIV;

    task automatic expect_done(input string tag, input int busy);
        exp_t e;
        e.tag = tag; e.din = m_din; e.cs = m_cs; e.err = m_err; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] c, input logic [SELW-1:0] s, input logic [7:0] o);
        @(negedge clock50);
        sd_cmd = c; sd_sel = s; sd_out = o; sd_signal = 1'b1;
        @(negedge clock50);
        @(negedge clock50);
        sd_signal = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clock50);
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            check({tag, "_complete"}, 0, 1);
            sb.delete();
        end
        @(negedge clock50);
    endtask

    task automatic short_cmd(input string tag, input logic [2:0] c,
                             input logic [SELW-1:0] s, input logic [7:0] o);
        expect_done(tag, 3);
        issue(c, s, o);
        wait_done(tag, 50);
    endtask

    task automatic do_xfer(input string tag, input logic [7:0] txb, input logic [7:0] rxb);
        int r0;
        dev_q.delete();
        dev_q.push_back(rxb);
        dev_fill = 8'hFF;
        dev_prime();
        r0 = rises;
        m_din = rxb;
        expect_done(tag, 16 * m_d + 1);
        issue(3'd1, '0, txb);
        wait_done(tag, 16 * m_d + 100);
        check({tag, "_mosi"},  mosi_sh,    txb);
        check({tag, "_rises"}, rises - r0, 8);
    endtask

    // dev_q must be loaded by the caller; the device returns 0xFF once it drains.
    task automatic do_wait(input string tag, input int n, input logic [7:0] last, input logic err);
        int r0;
        dev_fill = 8'hFF;
        dev_prime();
        r0 = rises;
        m_din = last;
        m_err = err;
        expect_done(tag, n * (16 * m_d + 1));
        issue(3'd6, '0, 8'h00);
        wait_done(tag, WAIT_MAX * (16 * m_d + 1) + 100);
        check({tag, "_rises"}, rises - r0, 8 * n);
    endtask

    task automatic check_reset(input string p);
        check({p, "_cs"},   SPI_CS,     3'b111);
        check({p, "_sclk"}, SPI_SCLK,   1'b0);
        check({p, "_mosi"}, SPI_MOSI,   1'b0);
        check({p, "_din"},  sd_din,     8'h00);
        check({p, "_busy"}, sd_busy,    1'b0);
        check({p, "_err"},  sd_err,     1'b0);
        check({p, "_tmo"},  sd_timeout, 1'b1);
    endtask

    initial begin
        int bsum;
        bit found;
        int tmo_at;

        repeat (3) @(negedge clock50);
        check_reset("rst");
        reset = 1'b0;

        // INIT: 80 slow clocks with CS high and MOSI high
        stats_clear();
        init_mon = 1'b1;
        begin
            int r0 = rises;
            expect_done("init", 2 * INIT_CLOCKS * SLOW_DIV + 1);
            issue(3'd0, '0, 8'h00);
            wait_done("init", 2 * INIT_CLOCKS * SLOW_DIV + 100);
            check("init_rises", rises - r0, INIT_CLOCKS);
        end
        init_mon = 1'b0;
        check("init_viol",    init_viol, 0);
        check("init_hi_min",  hi_min,    SLOW_DIV);
        check("init_hi_max",  hi_max,    SLOW_DIV);
        check("init_per_min", per_min,   2 * SLOW_DIV);
        check("init_per_max", per_max,   2 * SLOW_DIV);
        check("init_sclk",    SPI_SCLK,  1'b0);
        check("init_mosi",    SPI_MOSI,  1'b0);
        m_d = SLOW_DIV;

        // SPEED 2, select line 1, exchange 0xA5 for 0x3C
        short_cmd("speed2", 3'd4, '0, 8'd2);
        m_d = 2;
        m_cs = 3'b101;
        short_cmd("cs_on1", 3'd2, 2'd1, 8'h00);
        do_xfer("xA5", 8'hA5, 8'h3C);

        // SPEED 0 is treated as divider 1
        short_cmd("speed0", 3'd4, '0, 8'd0);
        m_d = 1;
        do_xfer("x5A", 8'h5A, 8'h81);

        // WAIT: three idle bytes, then a response
        dev_q.delete();
        dev_q.push_back(8'hFF); dev_q.push_back(8'hFF);
        dev_q.push_back(8'hFF); dev_q.push_back(8'h00);
        do_wait("wait4", 4, 8'h00, 1'b0);

        // WAIT with no response: exhausts after WAIT_MAX bytes
        dev_q.delete();
        do_wait("waitmax", WAIT_MAX, 8'hFF, 1'b1);

        // Chip-select handling; sd_err stays set through non-WAIT commands
        m_cs = 3'b111;
        short_cmd("cs_on3", 3'd2, 2'd3, 8'h00);
        m_cs = 3'b110;
        short_cmd("cs_on0", 3'd2, 2'd0, 8'h00);
        m_cs = 3'b111;
        expect_done("cs_off", 3);
        issue(3'd3, '0, 8'h00);
        // Strobe rising inside the last busy cycle must be ignored
        @(negedge clock50);
        sd_signal = 1'b1;
        wait_done("cs_off", 50);
        bsum = 0;
        repeat (10) begin
            @(negedge clock50);
            if (sd_busy) bsum++;
        end
        check("late_strobe_busy", bsum, 0);
        sd_signal = 1'b0;
        short_cmd("noop", 3'd7, '0, 8'h00);

        // SLOW restores the slow divider for transfers
        short_cmd("slow", 3'd5, '0, 8'h00);
        m_d = SLOW_DIV;
        do_xfer("xslow", 8'h0F, 8'hF0);

        // Reset in the middle of a transfer
        dev_prime();
        issue(3'd1, '0, 8'hC3);
        repeat (10) @(negedge clock50);
        reset = 1'b1;
        @(negedge clock50);
        check_reset("midrst");
        reset = 1'b0;
        m_din = 8'h00; m_err = 1'b0; m_cs = 3'b111; m_d = SLOW_DIV;
        bsum = 0;
        repeat (20) begin
            @(negedge clock50);
            if (sd_busy) bsum++;
        end
        check("post_rst_busy", bsum, 0);

        // Fresh command after reset, then the idle timeout
        m_cs = 3'b011;
        short_cmd("cs_on2", 3'd2, 2'd2, 8'h00);
        check("tmo_low", sd_timeout, 1'b0);
        found  = 0;
        tmo_at = -1;
        for (int i = 0; i < TIMEOUT_CNT + 50 && !found; i++) begin
            @(negedge clock50);
            if (sd_timeout) begin
                found  = 1;
                tmo_at = cyc - cyc_done;
            end
        end
        check("tmo_cycles", tmo_at, TIMEOUT_CNT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
